// File: rtl/rca_grid_dispatch.sv
// rca_grid_dispatch: in-order RCA instruction buffer and grid dispatch/switch control.
// Optional same-cycle dispatch bypass: define RCA_DISPATCH_BYPASS_EN.
module rca_grid_dispatch #(
  parameter int DEPTH          = 4,
  parameter int XLEN           = 32,
  parameter int NUM_READ_PORTS = 5,
  parameter int NUM_RCAS       = 4,
  parameter int ID_W           = 3,
  localparam int SEL_W         = $clog2(NUM_RCAS),
  localparam int AW            = $clog2(DEPTH),
  localparam int PW            = AW + 1,
  localparam int RSW           = NUM_READ_PORTS * XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [ID_W-1:0]  issue_id,
  input  logic             issue_fb,
  input  logic [SEL_W-1:0] issue_rca_sel,
  input  logic [RSW-1:0]   issue_rs_data,
  output logic [RSW-1:0]   buf_rs_data,
  output logic             buf_rs_data_valid,
  input  logic             grid_ready,
  output logic [SEL_W-1:0] rca_sel_buf,
  output logic [SEL_W-1:0] currently_running_rca,
  output logic             clear_fifos,
  input  logic             wb_committing,
  output logic [ID_W-1:0]  wb_id,
  output logic             wb_fb_instr,
  output logic             fifo_populated
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_disp_ptr;
  logic [PW-1:0]    r_cmt_ptr;
  logic [SEL_W-1:0] r_cur_rca;
  logic [SEL_W-1:0] r_pend_sel;

  logic [ID_W-1:0]  r_id  [DEPTH];
  logic             r_fb  [DEPTH];
  logic [SEL_W-1:0] r_rca [DEPTH];
  logic [RSW-1:0]   r_rs  [DEPTH];

  logic [PW-1:0] w_count;
  logic [PW-1:0] w_pending;
  logic          w_full;
  logic          w_empty;
  logic          w_match;
  logic          w_ready;
  logic          w_latch;
  logic          w_clear;
  logic          w_accept;
  logic          w_disp;
  logic          w_commit;
  logic          w_byp;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_disp_idx;
  logic [AW-1:0] w_cmt_idx;

  assign w_count    = r_wr_ptr - r_cmt_ptr;
  assign w_pending  = r_wr_ptr - r_disp_ptr;
  assign w_full     = (w_count == PW'(DEPTH));
  assign w_empty    = (w_count == '0);
  assign w_match    = (issue_rca_sel == r_cur_rca);
  assign w_wr_idx   = r_wr_ptr[AW-1:0];
  assign w_disp_idx = r_disp_ptr[AW-1:0];
  assign w_cmt_idx  = r_cmt_ptr[AW-1:0];

  // Ready is held low while reset is asserted.
  assign issue_ready = w_ready & rst;
  assign w_accept    = issue_valid & issue_ready;
  assign w_disp      = buf_rs_data_valid & grid_ready;
  assign w_commit    = wb_committing & (r_cmt_ptr != r_disp_ptr);

`ifdef RCA_DISPATCH_BYPASS_EN
  assign w_byp = w_accept & (w_pending == '0) &
                 ((r_state == S_IDLE) | (r_state == S_RUN));
`else
  assign w_byp = 1'b0;
`endif

  assign clear_fifos           = w_clear;
  assign currently_running_rca = r_cur_rca;
  assign fifo_populated        = ~w_empty;

  // Next state, handshake and RCA-switch control.
  always_comb begin
    w_nxt   = r_state;
    w_ready = 1'b0;
    w_latch = 1'b0;
    w_clear = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = w_match;
        if (issue_valid) begin
          if (w_match) begin
            w_nxt = S_RUN;
          end else begin
            w_latch = 1'b1;
            w_nxt   = S_FLUSH;
          end
        end
      end
      S_RUN: begin
        w_ready = ~w_full & w_match;
        if (issue_valid && !w_match) begin
          w_latch = 1'b1;
          w_nxt   = S_DRAIN;
        end else if (w_empty && !(issue_valid && w_ready)) begin
          w_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_empty) w_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_clear = 1'b1;
        w_nxt   = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register and running-RCA bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cur_rca  <= '0;
      r_pend_sel <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_latch) r_pend_sel <= issue_rca_sel;
      if (r_state == S_FLUSH) r_cur_rca <= r_pend_sel;
    end
  end

  // Write, dispatch and commit pointers move independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_disp_ptr <= '0;
      r_cmt_ptr  <= '0;
    end else begin
      if (w_accept) r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_disp)   r_disp_ptr <= r_disp_ptr + 1'b1;
      if (w_commit) r_cmt_ptr  <= r_cmt_ptr + 1'b1;
    end
  end

  // Entry storage; bypassed entries are still written for writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]  <= '0;
        r_fb[i]  <= 1'b0;
        r_rca[i] <= '0;
        r_rs[i]  <= '0;
      end
    end else if (w_accept) begin
      r_id[w_wr_idx]  <= issue_id;
      r_fb[w_wr_idx]  <= issue_fb;
      r_rca[w_wr_idx] <= issue_rca_sel;
      r_rs[w_wr_idx]  <= issue_rs_data;
    end
  end

  // Grid-facing view of the oldest undispatched entry.
  always_comb begin
    buf_rs_data_valid = (w_pending != '0);
    buf_rs_data       = '0;
    rca_sel_buf       = '0;
    if (buf_rs_data_valid) begin
      buf_rs_data = r_rs[w_disp_idx];
      rca_sel_buf = r_rca[w_disp_idx];
    end
    if (w_byp) begin
      buf_rs_data_valid = 1'b1;
      buf_rs_data       = issue_rs_data;
      rca_sel_buf       = issue_rca_sel;
    end
  end

  // Writeback-facing view of the oldest uncommitted entry.
  always_comb begin
    wb_id       = '0;
    wb_fb_instr = 1'b0;
    if (!w_empty) begin
      wb_id       = r_id[w_cmt_idx];
      wb_fb_instr = r_fb[w_cmt_idx];
    end
  end

endmodule

// File: tb/tb_rca_grid_dispatch.sv
// tb_rca_grid_dispatch: scoreboard bench for rca_grid_dispatch.
// Directed vectors; monitor checks dispatch order and commit IDs.
module tb_rca_grid_dispatch;

  localparam int RSW = 160;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           issue_valid = 1'b0;
  logic           issue_ready;
  logic [2:0]     issue_id = '0;
  logic           issue_fb = 1'b0;
  logic [1:0]     issue_rca_sel = '0;
  logic [RSW-1:0] issue_rs_data = '0;
  logic [RSW-1:0] buf_rs_data;
  logic           buf_rs_data_valid;
  logic           grid_ready = 1'b0;
  logic [1:0]     rca_sel_buf;
  logic [1:0]     currently_running_rca;
  logic           clear_fifos;
  logic           wb_committing = 1'b0;
  logic [2:0]     wb_id;
  logic           wb_fb_instr;
  logic           fifo_populated;

  rca_grid_dispatch dut (
    .clk                   (clk),
    .rst                   (rst),
    .issue_valid           (issue_valid),
    .issue_ready           (issue_ready),
    .issue_id              (issue_id),
    .issue_fb              (issue_fb),
    .issue_rca_sel         (issue_rca_sel),
    .issue_rs_data         (issue_rs_data),
    .buf_rs_data           (buf_rs_data),
    .buf_rs_data_valid     (buf_rs_data_valid),
    .grid_ready            (grid_ready),
    .rca_sel_buf           (rca_sel_buf),
    .currently_running_rca (currently_running_rca),
    .clear_fifos           (clear_fifos),
    .wb_committing         (wb_committing),
    .wb_id                 (wb_id),
    .wb_fb_instr           (wb_fb_instr),
    .fifo_populated        (fifo_populated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     id;
    logic           fb;
    logic [1:0]     sel;
    logic [RSW-1:0] rs;
  } ent_t;

  ent_t exp_disp[$];
  ent_t exp_cmt[$];
  int   checks  = 0;
  int   errors  = 0;
  int   m_ndisp = 0;
  int   clr_cnt = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  function automatic logic [RSW-1:0] mk_rs(input int base);
    logic [RSW-1:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[k*32 +: 32] = 32'(base + k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic fb,
                      input logic [1:0] sel, input logic [RSW-1:0] rs);
    ent_t e;
    e.id  = id;
    e.fb  = fb;
    e.sel = sel;
    e.rs  = rs;
    exp_disp.push_back(e);
    exp_cmt.push_back(e);
  endtask

  // Called one time unit after a rising edge; returns likewise.
  task automatic issue(input logic [2:0] id, input logic fb,
                       input logic [1:0] sel, input logic [RSW-1:0] rs,
                       output int waits);
    bit done;
    waits = 0;
    done  = 1'b0;
    issue_valid   = 1'b1;
    issue_id      = id;
    issue_fb      = fb;
    issue_rca_sel = sel;
    issue_rs_data = rs;
    while (!done) begin
      #2;
      if (issue_ready) begin
        push(id, fb, sel, rs);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 60) begin
          checks++;
          errors++;
          $display("FAIL issue_timeout act=%0d req=accept", waits);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
  endtask

  // Scoreboard monitor: dispatch order, hold stability and commit IDs.
  always @(negedge clk) begin
    bit d;
    d = 1'b0;
    if (clear_fifos) clr_cnt++;
    if (rst) begin
      if (buf_rs_data_valid) begin
        if (exp_disp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_unexpected act=%0h req=none", buf_rs_data);
        end else begin
          chk("disp_rs", buf_rs_data, exp_disp[0].rs);
          chk("disp_sel", rca_sel_buf, exp_disp[0].sel);
          if (grid_ready) begin
            void'(exp_disp.pop_front());
            d = 1'b1;
          end
        end
      end
      if (wb_committing && m_ndisp > 0) begin
        if (exp_cmt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmt_unexpected act=%0h req=none", wb_id);
        end else begin
          chk("cmt_id", wb_id, exp_cmt[0].id);
          chk("cmt_fb", wb_fb_instr, exp_cmt[0].fb);
          void'(exp_cmt.pop_front());
        end
        m_ndisp--;
      end
      if (d) m_ndisp++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", issue_ready, 0);
    chk("rst_valid", buf_rs_data_valid, 0);
    chk("rst_data", buf_rs_data, 0);
    chk("rst_selbuf", rca_sel_buf, 0);
    chk("rst_cur", currently_running_rca, 0);
    chk("rst_clear", clear_fifos, 0);
    chk("rst_wbid", wb_id, 0);
    chk("rst_wbfb", wb_fb_instr, 0);
    chk("rst_pop", fifo_populated, 0);
    step();
    rst = 1'b1;
    step();

    // Single instruction end to end.
    grid_ready = 1'b1;
    issue(3'd3, 1'b1, 2'd0, mk_rs(1), w);
    @(negedge clk);
`ifndef RCA_DISPATCH_BYPASS_EN
    chk("t1_valid_n1", buf_rs_data_valid, 1);
`endif
    chk("t1_wbid", wb_id, 3);
    chk("t1_wbfb", wb_fb_instr, 1);
    chk("t1_pop", fifo_populated, 1);
    step();
    @(negedge clk);
    chk("t1_valid_once", buf_rs_data_valid, 0);
    step();
    wb_committing = 1'b1;
    step();
    wb_committing = 1'b0;
    @(negedge clk);
    chk("t1_pop_fall", fifo_populated, 0);
    step();

    // Fill with grid stalled, illegal commits, drain, wrap.
    grid_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(3'(i), i[0], 2'd0, mk_rs(16 * (i + 1)), w);
    issue_valid   = 1'b1;
    issue_rca_sel = 2'd0;
    #2;
    chk("t2_full_ready", issue_ready, 0);
    issue_valid = 1'b0;
    step();
    wb_committing = 1'b1;
    repeat (2) step();
    wb_committing = 1'b0;
    @(negedge clk);
    chk("t2_pop", fifo_populated, 1);
    chk("t2_head_id", wb_id, 0);
    step();
    grid_ready = 1'b1;
    repeat (6) step();
    wb_committing = 1'b1;
    repeat (4) step();
    wb_committing = 1'b0;
    @(negedge clk);
    chk("t2_empty", fifo_populated, 0);
    step();
    issue(3'd4, 1'b0, 2'd0, mk_rs(100), w);
    issue(3'd5, 1'b1, 2'd0, mk_rs(200), w);
    repeat (3) step();
    wb_committing = 1'b1;
    repeat (2) step();
    wb_committing = 1'b0;
    @(negedge clk);
    chk("t2_wrap_empty", fifo_populated, 0);
    step();
    step();

    // Switch RCA from an empty buffer.
    clr_cnt = 0;
    issue(3'd6, 1'b0, 2'd2, mk_rs(300), w);
    chk("t3_waits", w, 2);
    chk("t3_clr", clr_cnt, 1);
    chk("t3_cur", currently_running_rca, 2);
    repeat (3) step();
    wb_committing = 1'b1;
    step();
    wb_committing = 1'b0;
    repeat (2) step();

    // Switch RCA with two entries outstanding.
    issue(3'd7, 1'b0, 2'd1, mk_rs(400), w);
    issue(3'd0, 1'b1, 2'd1, mk_rs(500), w);
    repeat (3) step();
    clr_cnt = 0;
    fork
      issue(3'd1, 1'b0, 2'd3, mk_rs(600), w);
      begin
        @(negedge clk);
        chk("t4_ready_run", issue_ready, 0);
        @(negedge clk);
        chk("t4_ready_drain", issue_ready, 0);
        @(posedge clk);
        #1;
        wb_committing = 1'b1;
        step();
        step();
        wb_committing = 1'b0;
      end
    join
    chk("t4_waits", w, 6);
    chk("t4_clr", clr_cnt, 1);
    chk("t4_cur", currently_running_rca, 3);
    repeat (3) step();
    wb_committing = 1'b1;
    step();
    wb_committing = 1'b0;
    step();

    // Accept, dispatch and commit in one cycle at count 2.
    grid_ready = 1'b1;
    issue(3'd2, 1'b0, 2'd3, mk_rs(700), w);
    repeat (3) step();
    grid_ready = 1'b0;
    issue(3'd3, 1'b1, 2'd3, mk_rs(800), w);
    issue_valid   = 1'b1;
    issue_id      = 3'd4;
    issue_fb      = 1'b0;
    issue_rca_sel = 2'd3;
    issue_rs_data = mk_rs(900);
    grid_ready    = 1'b1;
    wb_committing = 1'b1;
    #2;
    chk("t5_ready", issue_ready, 1);
    push(3'd4, 1'b0, 2'd3, mk_rs(900));
    step();
    issue_valid   = 1'b0;
    wb_committing = 1'b0;
    grid_ready    = 1'b0;
    @(negedge clk);
    chk("t5_pop", fifo_populated, 1);
    chk("t5_head_id", wb_id, 3);
    chk("t5_pending", buf_rs_data_valid, 1);
    step();
    grid_ready = 1'b1;
    repeat (2) step();
    wb_committing = 1'b1;
    repeat (2) step();
    wb_committing = 1'b0;
    @(negedge clk);
    chk("t5_empty", fifo_populated, 0);
    step();

    // Reset while draining.
    grid_ready = 1'b0;
    issue(3'd5, 1'b0, 2'd3, mk_rs(1000), w);
    issue(3'd6, 1'b1, 2'd3, mk_rs(1100), w);
    issue_valid   = 1'b1;
    issue_rca_sel = 2'd0;
    step();
    step();
    clr_cnt = 0;
    rst = 1'b0;
    #2;
    chk("t6_ready", issue_ready, 0);
    chk("t6_valid", buf_rs_data_valid, 0);
    chk("t6_data", buf_rs_data, 0);
    chk("t6_selbuf", rca_sel_buf, 0);
    chk("t6_cur", currently_running_rca, 0);
    chk("t6_clear", clear_fifos, 0);
    chk("t6_wbid", wb_id, 0);
    chk("t6_wbfb", wb_fb_instr, 0);
    chk("t6_pop", fifo_populated, 0);
    issue_valid = 1'b0;
    exp_disp.delete();
    exp_cmt.delete();
    m_ndisp = 0;
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    chk("t6_no_clear", clr_cnt, 0);

    // Normal operation after reset.
    grid_ready = 1'b1;
    issue(3'd7, 1'b1, 2'd0, mk_rs(1200), w);
    chk("t7_waits", w, 0);
    repeat (2) step();
    wb_committing = 1'b1;
    step();
    wb_committing = 1'b0;
    repeat (2) step();

`ifdef RCA_DISPATCH_BYPASS_EN
    grid_ready    = 1'b0;
    issue_valid   = 1'b1;
    issue_id      = 3'd2;
    issue_fb      = 1'b0;
    issue_rca_sel = 2'd0;
    issue_rs_data = mk_rs(1300);
    #2;
    chk("byp_valid", buf_rs_data_valid, 1);
    chk("byp_data", buf_rs_data, mk_rs(1300));
    push(3'd2, 1'b0, 2'd0, mk_rs(1300));
    step();
    issue_valid = 1'b0;
    grid_ready  = 1'b1;
    repeat (2) step();
    wb_committing = 1'b1;
    step();
    wb_committing = 1'b0;
    repeat (2) step();
`endif

    chk("end_disp_q", exp_disp.size(), 0);
    chk("end_cmt_q", exp_cmt.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_grid_dispatch.md
# rca_grid_dispatch

Instruction buffer and dispatch controller directly upstream of the RCA unit's grid, IO units and grid writeback. Accepts issued RCA use-instructions (ID, feedback flag, target RCA, source operands) and queues them in order. Presents each entry's operands to the grid once, then exposes the oldest outstanding entry's ID and feedback flag to writeback until it commits. It owns RCA switching: it drains in-flight work, then pulses the IO-unit FIFO clear before a different RCA starts running.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- XLEN, 32, operand width
- NUM_READ_PORTS, 5, source operands per instruction
- NUM_RCAS, 4, number of configurable RCAs
- ID_W, 3, instruction ID width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  use-instruction offered
- issue_ready  out  1  instruction accepted when valid&&ready
- issue_id  in  ID_W  instruction ID
- issue_fb  in  1  feedback-variant instruction
- issue_rca_sel  in  clog2(NUM_RCAS)  target RCA
- issue_rs_data  in  NUM_READ_PORTS×XLEN  source operands
- buf_rs_data  out  NUM_READ_PORTS×XLEN  operands of the next undispatched entry
- buf_rs_data_valid  out  1  buf_rs_data is valid
- grid_ready  in  1  grid consumes buf_rs_data this cycle when valid
- rca_sel_buf  out  clog2(NUM_RCAS)  RCA of the next undispatched entry
- currently_running_rca  out  clog2(NUM_RCAS)  RCA whose config drives the grid
- clear_fifos  out  1  one-cycle IO-unit FIFO reset pulse
- wb_committing  in  1  writeback retires the head entry
- wb_id  out  ID_W  ID of the head entry
- wb_fb_instr  out  1  feedback flag of the head entry
- fifo_populated  out  1  at least one entry outstanding

## Operation
- Storage: a DEPTH-entry circular buffer with three pointers, each clog2(DEPTH)+1 bits with a wrap bit:
  - wr_ptr: advances on accept
  - disp_ptr: advances when buf_rs_data_valid && grid_ready
  - cmt_ptr: advances on a legal commit
- Invariant: cmt_ptr ≤ disp_ptr ≤ wr_ptr.
- Derived counts:
  - count = wr_ptr − cmt_ptr
  - pending = wr_ptr − disp_ptr
  - fifo_populated = (count ≠ 0)
- Commit is legal only when cmt_ptr ≠ disp_ptr. An illegal wb_committing is ignored and the pointer is not changed.
- wb_id and wb_fb_instr come from the entry at cmt_ptr. When count==0 they read 0.
- FSM states: IDLE, RUN, DRAIN, FLUSH.
  - IDLE: count==0. On issue_valid:
    - matching RCA: accept, go to RUN.
    - mismatching RCA: issue_ready=0, latch the sel, go to FLUSH.
  - RUN: accept while count<DEPTH and issue_rca_sel==currently_running_rca. On mismatch: issue_ready=0, latch the sel, go to DRAIN. When count reaches 0 with nothing accepted, go to IDLE.
  - DRAIN: issue_ready=0. When count==0, go to FLUSH.
  - FLUSH: issue_ready=0 and clear_fifos=1 for exactly one cycle. currently_running_rca takes the latched sel. Next state is IDLE.
- issue_ready is 0 when count==DEPTH, even if a commit happens in the same cycle. There is no same-cycle refill of a full buffer.
- Accept, dispatch and commit may all occur in the same cycle. The pointers update independently.
- Reset values of outputs:
  - issue_ready=0; all other 1-bit outputs 0.
  - buf_rs_data=0, rca_sel_buf=0, currently_running_rca=0, wb_id=0.
  - FSM in IDLE, all pointers 0.
  - Reset mid-operation discards every entry and never asserts clear_fifos.

## Timing
- Accept in cycle N → buf_rs_data_valid in N+1 (registered output), provided no older entry is pending.
- buf_rs_data and rca_sel_buf hold stable while valid && !grid_ready.
- A commit in cycle N changes wb_id/wb_fb_instr in N+1. fifo_populated falls in N+1 when the last entry retires.
- RCA switch from an empty buffer (IDLE with mismatching sel):
  - FLUSH in N+1, IDLE in N+2.
  - Accept in N+2, so the switch costs 2 cycles.
- RCA switch with work outstanding: DRAIN until count==0, then FLUSH for 1 cycle, then IDLE.
- issue_ready is combinational from state, count and issue_rca_sel. It never depends on grid_ready or wb_committing.

## Configuration
- RCA_DISPATCH_BYPASS_EN defined: when the state is IDLE or RUN, pending==0 and the RCA matches, an accepted instruction drives buf_rs_data, buf_rs_data_valid and rca_sel_buf combinationally in the same cycle.
  - If grid_ready is also high, wr_ptr and disp_ptr advance together.
  - The entry is still written, because writeback needs its ID.
- Undefined: no bypass; dispatch latency is always ≥1 cycle.

## Test plan
- Reset; issue id=3, fb=1, sel=0, rs={1,2,3,4,5} with grid_ready=1:
  - buf_rs_data_valid for one cycle at N+1 with those operands.
  - wb_id=3, wb_fb_instr=1, fifo_populated=1.
  - wb_committing → fifo_populated=0 one cycle later.
- Issue 4 entries with grid_ready=0 → issue_ready=0 at count=4. Commit attempts are ignored (none dispatched). Then grid_ready=1 → 4 dispatches in order; commit all; pointers wrap; issue 2 more correctly.
- Buffer empty, currently_running_rca=0, issue sel=2:
  - clear_fifos high exactly one cycle.
  - currently_running_rca=2.
  - Accepted 2 cycles after first valid.
- 2 entries outstanding on RCA 1, issue sel=3 → DRAIN holds issue_ready=0 until both commit, then FLUSH pulse, then accept.
- Accept, dispatch and commit in the same cycle with count=2 → count stays 2, order preserved.
- Assert rst mid-DRAIN → all outputs at reset values, no clear_fifos pulse.
- With RCA_DISPATCH_BYPASS_EN: issue into an empty RUN state → buf_rs_data_valid in the same cycle.
